// File: rtl/leitor_sete_segmentos.sv
// rtl/leitor_sete_segmentos.sv - multiplexed 7-segment bus reader with frame assembly
// Optional hex glyph decode (A..F) is compiled in with `define LEITOR_HEX_EN.
module leitor_sete_segmentos #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 3
) (
  input  logic                  iClk,
  input  logic                  iRst,
  input  logic                  iA,
  input  logic                  iB,
  input  logic                  iC,
  input  logic                  iD,
  input  logic                  iE,
  input  logic                  iF,
  input  logic                  iG,
  input  logic [DIGITS-1:0]     iDig,
  output logic [4*DIGITS-1:0]   oValor,
  output logic                  oValido,
  output logic [DIGITS-1:0]     oDigErro
);

  localparam int SW = DIGITS + 7;
  localparam int CW = 5;

  typedef enum logic {COLETA, PUBLICA} estado_t;

  estado_t              state_q;
  logic [SW-1:0]        sample_q, sample_in;
  logic [CW-1:0]        run_q, run_d;
  logic [DIGITS-1:0]    seen_q, seen_d;
  logic [DIGITS-1:0]    err_q, err_d;
  logic [4*DIGITS-1:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0]    samp_dig;
  logic                 onehot, accept, publish;
  logic [4:0]           dec;

  // Returns {valid, nibble}; segments ordered a..g with a as MSB.
  function automatic logic [4:0] decode(input logic [6:0] seg);
    case (seg)
      7'b1111110: decode = {1'b1, 4'h0};
      7'b0110000: decode = {1'b1, 4'h1};
      7'b1101101: decode = {1'b1, 4'h2};
      7'b1111001: decode = {1'b1, 4'h3};
      7'b0110011: decode = {1'b1, 4'h4};
      7'b1011011: decode = {1'b1, 4'h5};
      7'b1011111: decode = {1'b1, 4'h6};
      7'b1110000: decode = {1'b1, 4'h7};
      7'b1111111: decode = {1'b1, 4'h8};
      7'b1111011: decode = {1'b1, 4'h9};
`ifdef LEITOR_HEX_EN
      7'b1110111: decode = {1'b1, 4'hA};
      7'b0011111: decode = {1'b1, 4'hB};
      7'b1001110: decode = {1'b1, 4'hC};
      7'b0111101: decode = {1'b1, 4'hD};
      7'b1001111: decode = {1'b1, 4'hE};
      7'b1000111: decode = {1'b1, 4'hF};
`endif
      default:    decode = {1'b0, 4'h0};
    endcase
  endfunction

  always_comb begin
    sample_in = {iDig, iA, iB, iC, iD, iE, iF, iG};
    if (sample_in == sample_q) begin
      run_d = (run_q == CW'(STABLE_CYCLES + 1)) ? run_q : run_q + 1'b1;
    end else begin
      run_d = CW'(1);
    end

    samp_dig = sample_q[SW-1:7];
    onehot   = (samp_dig != '0) && ((samp_dig & (samp_dig - DIGITS'(1))) == '0);
    accept   = onehot && (run_q == CW'(STABLE_CYCLES));
    dec      = decode(sample_q[6:0]);
    publish  = (state_q == COLETA) && (&seen_q);

    // A digit accepted on the publish edge lands in the next frame.
    seen_d   = publish ? '0 : seen_q;
    err_d    = publish ? '0 : err_q;
    shadow_d = shadow_q;
    if (accept) begin
      for (int k = 0; k < DIGITS; k++) begin
        if (samp_dig[k]) begin
          seen_d[k] = 1'b1;
          if (dec[4]) begin
            shadow_d[4*k +: 4] = dec[3:0];
            err_d[k]           = 1'b0;
          end else begin
            err_d[k] = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q  <= COLETA;
      sample_q <= '0;
      run_q    <= '0;
      seen_q   <= '0;
      err_q    <= '0;
      shadow_q <= '0;
      oValor   <= '0;
      oValido  <= 1'b0;
      oDigErro <= '0;
    end else begin
      sample_q <= sample_in;
      run_q    <= run_d;
      seen_q   <= seen_d;
      err_q    <= err_d;
      shadow_q <= shadow_d;
      case (state_q)
        COLETA: begin
          if (publish) begin
            oValor   <= shadow_q;
            oDigErro <= err_q;
            oValido  <= 1'b1;
            state_q  <= PUBLICA;
          end else begin
            oValido  <= 1'b0;
          end
        end
        default: begin
          oValido <= 1'b0;
          state_q <= COLETA;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_leitor_sete_segmentos.sv
// tb/tb_leitor_sete_segmentos.sv - directed table-driven bench for leitor_sete_segmentos
module tb_leitor_sete_segmentos;

  logic        iClk = 1'b0;
  logic        iRst;
  logic        iA, iB, iC, iD, iE, iF, iG;
  logic [3:0]  iDig;
  logic [15:0] oValor;
  logic        oValido;
  logic [3:0]  oDigErro;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  leitor_sete_segmentos #(.DIGITS(4), .STABLE_CYCLES(3)) dut (
    .iClk(iClk), .iRst(iRst),
    .iA(iA), .iB(iB), .iC(iC), .iD(iD), .iE(iE), .iF(iF), .iG(iG),
    .iDig(iDig), .oValor(oValor), .oValido(oValido), .oDigErro(oDigErro)
  );

  always #5 iClk = ~iClk;

  always @(negedge iClk) if (oValido === 1'b1) pulses++;

  typedef struct {
    logic [3:0][6:0] seg;
    logic [15:0]     val;
    logic [3:0]      err;
    string           name;
  } frame_t;

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic put(input logic [3:0] dig, input logic [6:0] seg, input int n);
    {iA, iB, iC, iD, iE, iF, iG} = seg;
    iDig = dig;
    repeat (n) tick();
  endtask

  task automatic run_frame(input frame_t f);
    int p0;
    p0 = pulses;
    for (int k = 0; k < 4; k++) put(4'(1) << k, f.seg[k], 3);
    put(4'b0000, 7'b0000000, 1);
    chk({f.name, "_early"}, 32'(oValido), 32'd0);
    tick();
    chk({f.name, "_valido"}, 32'(oValido), 32'd1);
    chk({f.name, "_valor"}, 32'(oValor), 32'(f.val));
    chk({f.name, "_erro"}, 32'(oDigErro), 32'(f.err));
    tick();
    chk({f.name, "_pulse_end"}, 32'(oValido), 32'd0);
    chk({f.name, "_pulse_cnt"}, 32'(pulses - p0), 32'd1);
  endtask

  frame_t frames[5];

  initial begin
    int p0;

    frames[0] = '{seg: {7'b1011011, 7'b1111111, 7'b0110000, 7'b1111001},
                  val: 16'h5813, err: 4'b0000, name: "full"};
    frames[1] = '{seg: {7'b1111011, 7'b0000001, 7'b1101101, 7'b1111110},
                  val: 16'h9820, err: 4'b0100, name: "invalid"};
`ifdef LEITOR_HEX_EN
    frames[2] = '{seg: {7'b0110011, 7'b1011111, 7'b1110000, 7'b1110111},
                  val: 16'h467A, err: 4'b0000, name: "hex_a"};
    frames[4] = '{seg: {7'b1001111, 7'b0111101, 7'b1001110, 7'b0011111},
                  val: 16'hEDCB, err: 4'b0000, name: "hex_bcde"};
`else
    frames[2] = '{seg: {7'b0110011, 7'b1011111, 7'b1110000, 7'b1110111},
                  val: 16'h4670, err: 4'b0001, name: "hex_a"};
    frames[4] = '{seg: {7'b1001111, 7'b0111101, 7'b1001110, 7'b0011111},
                  val: 16'h2096, err: 4'b1111, name: "hex_bcde"};
`endif
    frames[3] = '{seg: {7'b1101101, 7'b1111110, 7'b1111011, 7'b1011111},
                  val: 16'h2096, err: 4'b0000, name: "dec"};

    iRst = 1'b1;
    put(4'b1010, 7'b1010101, 2);
    chk("reset_valor", 32'(oValor), 32'h0);
    chk("reset_valido", 32'(oValido), 32'd0);
    chk("reset_erro", 32'(oDigErro), 32'd0);
    iRst = 1'b0;

    // Short dwell and multi-hot select must not register digit 0.
    p0 = pulses;
    put(4'b0001, 7'b0110000, 2);
    put(4'b0000, 7'b0000000, 2);
    put(4'b0011, 7'b0110000, 4);
    put(4'b0010, 7'b0110011, 3);
    put(4'b0100, 7'b1110000, 3);
    put(4'b1000, 7'b1111001, 3);
    put(4'b0000, 7'b0000000, 6);
    chk("glitch_no_pulse", 32'(pulses - p0), 32'd0);
    put(4'b0001, 7'b0110000, 3);
    put(4'b0000, 7'b0000000, 2);
    chk("glitch_completion_valido", 32'(oValido), 32'd1);
    chk("glitch_completion_valor", 32'(oValor), 32'h3741);
    chk("glitch_completion_erro", 32'(oDigErro), 32'd0);
    tick();

    for (int i = 0; i < 5; i++) run_frame(frames[i]);

    // Partial frame followed by reset is discarded.
    put(4'b0001, 7'b1111011, 3);
    put(4'b0010, 7'b1111011, 3);
    put(4'b0000, 7'b0000000, 1);
    iRst = 1'b1;
    put(4'b0000, 7'b0000000, 2);
    chk("midreset_valor", 32'(oValor), 32'h0);
    chk("midreset_valido", 32'(oValido), 32'd0);
    chk("midreset_erro", 32'(oDigErro), 32'd0);
    iRst = 1'b0;
    run_frame('{seg: {7'b0110011, 7'b1111001, 7'b1101101, 7'b0110000},
                val: 16'h4321, err: 4'b0000, name: "after_reset"});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/leitor_sete_segmentos.md
# leitor_sete_segmentos

Reader for a multiplexed 7-segment display bus: samples segment lines a–g plus one-hot digit-select lines, waits for each pattern to be stable, decodes it back to a 4-bit value using the same glyph table the `traducao` encoder drives, and assembles a multi-digit frame. It sits on the display side of the `traducao` path and is used for loopback checking and for capturing externally driven displays.

## Interface
- `DIGITS`, default 4: number of multiplexed digit positions.
- `STABLE_CYCLES`, default 3: number of consecutive identical samples required before a pattern is accepted. Legal range is 2–15.
- `iClk`: input, 1 bit. Single clock; everything is synchronous to its rising edge.
- `iRst`: input, 1 bit. Synchronous, active-high reset.
- `iA`, `iB`, `iC`, `iD`, `iE`, `iF`, `iG`: input, 1 bit each. Segment lines, active-high.
- `iDig`: input, `DIGITS` bits. Digit select, active-high. Expected to be one-hot or all-zero (blanking).
- `oValor`: output, 4*`DIGITS` bits. Last complete frame. Digit *k* occupies bits [4k+3:4k], ordered W X Y Z with W as the MSB.
- `oValido`: output, 1 bit. One-cycle pulse when `oValor` is updated.
- `oDigErro`: output, `DIGITS` bits. Per-digit invalid-pattern flags for the last frame.

## Operation
- **Input sampling:** `{iDig, iA..iG}` is registered into a sample register at every edge.
  - If the new sample equals the previous one, the run counter increments, saturating at `STABLE_CYCLES`+1.
  - Otherwise the run counter is set to 1.
- **Acceptance condition:** a pattern is accepted when the run counter equals `STABLE_CYCLES` and `iDig` in the sample register is exactly one-hot.
  - A pattern held indefinitely is accepted only once.
  - Blanking (`iDig` all zero) and multi-hot `iDig` are never accepted and have no effect.
- **Glyph table** (a..g), W X Y Z = 0..9:
  - 0 → 1111110
  - 1 → 0110000
  - 2 → 1101101
  - 3 → 1111001
  - 4 → 0110011
  - 5 → 1011011
  - 6 → 1011111
  - 7 → 1110000
  - 8 → 1111111
  - 9 → 1111011
- **Glyph table**, A..F (only when hex decode is compiled in; see Configuration):
  - A → 1110111
  - b → 0011111
  - C → 1001110
  - d → 0111101
  - E → 1001111
  - F → 1000111
- **Accepting a digit:** sets `seen[k]` for the selected digit *k*.
  - If the pattern is in the glyph table, `shadow[k]` gets the decoded nibble and `err[k]` is cleared.
  - Otherwise `shadow[k]` is unchanged and `err[k]` is set.
  - Re-accepting the same digit within a frame overwrites it; the latest acceptance wins.
- **Frame completion:** when all `seen` bits are set, on the next edge:
  - `oValor` ← `shadow`;
  - `oDigErro` ← `err`;
  - `oValido` ← 1 for exactly one cycle;
  - `seen` and `err` are cleared.
  - `shadow` is retained.
- **States:**
  - COLETA: collecting digits.
  - PUBLICA: single cycle in which the frame is published.
  - PUBLICA always returns to COLETA.
  - An acceptance arriving during PUBLICA counts toward the next frame.

## Timing
- Input takes a new value sampled at edge e0 and is held through edge e(S−1), where S = `STABLE_CYCLES`.
  - The shadow slot is written at edge e(S).
  - If that completes the frame, `oValido` is high between edges e(S+1) and e(S+2).
- Minimum per-digit dwell on the bus is S cycles. Shorter dwells are discarded.
- Reset values, with `iRst` sampled high at an edge:
  - `oValor` = 0, `oValido` = 0, `oDigErro` = 0.
  - `seen`, `err`, `shadow` = 0; run counter = 0; sample register = 0; state = COLETA.
- Reset mid-frame discards the partial frame. Reset has priority over every other event in the same cycle.
- No input combinational path reaches any output; all outputs are registered.

## Configuration
- `LEITOR_HEX_EN`:
  - Defined: glyphs A–F decode to 10–15.
  - Undefined: those six patterns are invalid and set `err[k]`, giving decimal-only reading with matching logic removed.

## Test plan
All scenarios use `DIGITS`=4 and `STABLE_CYCLES`=3.
- **Reset:** hold `iRst`=1 for 2 cycles with arbitrary inputs → `oValor`=16'h0000, `oValido`=0, `oDigErro`=4'b0000.
- **Full frame:** drive each digit for 3 cycles: `iDig`=0001/1111001, 0010/0110000, 0100/1111111, 1000/1011011 → one `oValido` pulse 2 cycles after the last digit's dwell, `oValor`=16'h5813, `oDigErro`=0.
- **Glitch rejection:** `iDig`=0001/0110000 for 2 cycles, then blanking → no acceptance; completing digits 1–3 alone produces no `oValido`.
- **Invalid pattern:** digit 2 driven with 0000001 in an otherwise valid frame → `oDigErro`=4'b0100; nibble 2 of `oValor` keeps its previous value.
- **Hex decode:** digit 0 driven with 1110111 → with `LEITOR_HEX_EN`, nibble 0 = 4'hA and no error; without it, `oDigErro[0]`=1.
- **Reset mid-frame:** reset after digits 0–1 are accepted, then a full 4-digit frame → exactly one `oValido`, after all four new digits, carrying only the new values.
